// File: rtl/fw_sweep_gen_if.sv
// Bus for the fw sweep generator: configuration handshake, abort,
// the generated frequency word with its strobe, and status.
// master = configuring side, slave = fw_sweep_gen.
interface fw_sweep_gen_if #(
  parameter int FW_W    = 10,
  parameter int DWELL_W = 16
);
  // Handshake: a configuration transfers on a rising clk edge where
  // cfg_valid and cfg_ready are both high (and abort is low); cfg_ready
  // is high only while the generator is idle.
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FW_W-1:0]    cfg_start;
  logic [FW_W-1:0]    cfg_stop;
  logic [FW_W-1:0]    cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_mode;
  logic               abort;
  logic [FW_W-1:0]    fw;
  logic               fw_strobe;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;

  modport master (
    output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, abort,
    input  cfg_ready, fw, fw_strobe, busy, done, state_dbg
  );

  modport slave (
    input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, abort,
    output cfg_ready, fw, fw_strobe, busy, done, state_dbg
  );
endinterface

// File: rtl/fw_sweep_gen.sv
// Frequency-word sweep generator feeding the DDFS phase accumulator.
// Steps fw from start to stop in clamped increments, holding each word
// dwell+1 cycles; one-shot or continuous triangle sweep.
// Optional macro FW_SWEEP_PAUSE_EN adds a pause input that freezes a
// sweep in progress.
module fw_sweep_gen #(
  parameter int FW_W    = 10,
  parameter int DWELL_W = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FW_SWEEP_PAUSE_EN
  input  logic pause,
`endif
  fw_sweep_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FW_W-1:0]    fw_q, fw_d;
  logic               strobe_q, strobe_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [FW_W-1:0]    start_q, start_d;
  logic [FW_W-1:0]    stop_q, stop_d;
  logic [FW_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic [FW_W-1:0]    target_q, target_d;
  logic               up_q, up_d;
  logic [FW_W-1:0]    swap_target;
  logic [FW_W-1:0]    swap_next;
  logic               pause_w;

`ifdef FW_SWEEP_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // One step toward tgt, computed one bit wider so overshoot and
  // borrow both clamp to the target instead of wrapping.
  function automatic logic [FW_W-1:0] step_toward(
    input logic [FW_W-1:0] cur,
    input logic [FW_W-1:0] stp,
    input logic [FW_W-1:0] tgt,
    input logic            up
  );
    logic [FW_W:0] wide;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, stp};
      if (wide > {1'b0, tgt}) wide = {1'b0, tgt};
    end else begin
      wide = {1'b0, cur} - {1'b0, stp};
      if (wide[FW_W] || (wide < {1'b0, tgt})) wide = {1'b0, tgt};
    end
    return wide[FW_W-1:0];
  endfunction

  // Next state, datapath and config latching; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    fw_d        = fw_q;
    strobe_d    = 1'b0;
    cnt_d       = cnt_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    target_d    = target_q;
    up_d        = up_q;
    swap_target = (target_q == stop_q) ? start_q : stop_q;
    swap_next   = step_toward(fw_q, step_q, swap_target, ~up_q);

    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            start_d  = bus.cfg_start;
            stop_d   = bus.cfg_stop;
            step_d   = (bus.cfg_step == '0) ? FW_W'(1) : bus.cfg_step;
            dwell_d  = bus.cfg_dwell;
            mode_d   = bus.cfg_mode;
            target_d = bus.cfg_stop;
            up_d     = (bus.cfg_stop >= bus.cfg_start);
            fw_d     = bus.cfg_start;
            strobe_d = 1'b1;
            cnt_d    = bus.cfg_dwell;
            state_d  = S_DWELL;
          end
        end
        S_DWELL: begin
          if (!pause_w) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (fw_q != target_q) begin
              fw_d     = step_toward(fw_q, step_q, target_q, up_q);
              strobe_d = 1'b1;
              cnt_d    = dwell_q;
            end else if (!mode_q) begin
              state_d = S_DONE;
            end else begin
              // Triangle turnaround: step straight toward the other end.
              target_d = swap_target;
              up_d     = ~up_q;
              fw_d     = swap_next;
              strobe_d = (swap_next != fw_q);
              cnt_d    = dwell_q;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fw_q     <= '0;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      mode_q   <= 1'b0;
      target_q <= '0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fw_q     <= fw_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      up_q     <= up_d;
    end
  end

  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.fw        = fw_q;
  assign bus.fw_strobe = strobe_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fw_sweep_gen.sv
// Directed bench for fw_sweep_gen: one-shot up/down sweeps with clamping,
// triangle mode, abort, handshake rules and async reset.
module tb_fw_sweep_gen;
  localparam int FW_W    = 10;
  localparam int DWELL_W = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fw_sweep_gen_if #(.FW_W(FW_W), .DWELL_W(DWELL_W)) bus ();
`ifdef FW_SWEEP_PAUSE_EN
  logic pause = 1'b0;
`endif

  fw_sweep_gen #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FW_SWEEP_PAUSE_EN
    .pause (pause),
`endif
    .bus   (bus)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [FW_W-1:0] exp_q[$];
  int pause_at  = -1;
  int pause_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic offer_cfg(input logic [FW_W-1:0] s, input logic [FW_W-1:0] p,
                           input logic [FW_W-1:0] st, input logic [DWELL_W-1:0] d,
                           input logic m);
    bus.cfg_start = s;
    bus.cfg_stop  = p;
    bus.cfg_step  = st;
    bus.cfg_dwell = d;
    bus.cfg_mode  = m;
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic add_word(input logic [FW_W-1:0] w, input int reps);
    repeat (reps) exp_q.push_back(w);
  endtask

  // Samples every busy cycle and compares it with exp_q; returns at the
  // negedge of the first idle cycle.
  task automatic run_sweep(input string tag, input int exp_strobes, input bit junk);
    logic [FW_W-1:0] got[$];
    int n = 0;
    int strobes = 0;
    int dones = 0;
    int done_idx = -1;
    while (n < 500) begin
      @(negedge clk);
      if (!bus.busy) break;
      got.push_back(bus.fw);
      strobes += int'(bus.fw_strobe);
      if (bus.done) begin
        dones++;
        done_idx = n;
      end
`ifdef FW_SWEEP_PAUSE_EN
      if (n == pause_at) pause = 1'b1;
      if (n == pause_at + pause_len) pause = 1'b0;
`endif
      if (junk) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_start = 10'd500;
        bus.cfg_stop  = 10'd3;
        bus.cfg_step  = 10'd1;
        bus.cfg_dwell = 16'd0;
        bus.cfg_mode  = 1'b1;
      end
      n++;
    end
    bus.cfg_valid = 1'b0;
    check({tag, "_timeout"}, 32'(n < 500), 1);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_fw%0d", tag, i), got[i], exp_q[i]);
    check({tag, "_strobes"}, strobes, exp_strobes);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_done_idx"}, done_idx, exp_q.size() - 1);
    check({tag, "_idle_fw"}, bus.fw, exp_q[exp_q.size()-1]);
    check({tag, "_idle_ready"}, bus.cfg_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    logic [FW_W-1:0] tri_seq [10] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd2,
                                      10'd1, 10'd0, 10'd1, 10'd2, 10'd3};
    int strobes;
    bus.cfg_valid = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_stop  = '0;
    bus.cfg_step  = '0;
    bus.cfg_dwell = '0;
    bus.cfg_mode  = 1'b0;
    bus.abort     = 1'b0;

    // Reset state
    #1;
    check("rst_fw", bus.fw, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_strobe", bus.fw_strobe, 0);
    check("rst_ready", bus.cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.cfg_ready, 1);

    // Up one-shot, with a competing config held valid throughout
    offer_cfg(10'd100, 10'd130, 10'd10, 16'd3, 1'b0);
    add_word(10'd100, 4); add_word(10'd110, 4); add_word(10'd120, 4);
    add_word(10'd130, 4); add_word(10'd130, 1);
    run_sweep("up", 4, 1'b1);

    // Down with clamp, accepted right after the previous done
    offer_cfg(10'd50, 10'd5, 10'd20, 16'd0, 1'b0);
    add_word(10'd50, 1); add_word(10'd30, 1); add_word(10'd10, 1);
    add_word(10'd5, 1); add_word(10'd5, 1);
    run_sweep("down", 4, 1'b0);

    // Overflow clamp at the top of the range
    offer_cfg(10'd1000, 10'd1023, 10'd50, 16'd1, 1'b0);
    add_word(10'd1000, 2); add_word(10'd1023, 2); add_word(10'd1023, 1);
    run_sweep("ovf", 2, 1'b0);

    // Step of zero behaves as one
    offer_cfg(10'd2, 10'd4, 10'd0, 16'd0, 1'b0);
    add_word(10'd2, 1); add_word(10'd3, 1); add_word(10'd4, 1); add_word(10'd4, 1);
    run_sweep("step0", 3, 1'b0);

    // start == stop one-shot
    offer_cfg(10'd7, 10'd7, 10'd5, 16'd2, 1'b0);
    add_word(10'd7, 3); add_word(10'd7, 1);
    run_sweep("flat", 1, 1'b0);

    // Triangle then abort while fw=2
    offer_cfg(10'd0, 10'd3, 10'd1, 16'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("tri_fw%0d", i), bus.fw, tri_seq[i]);
      check($sformatf("tri_done%0d", i), bus.done, 0);
    end
    @(negedge clk);
    check("tri_pre_abort_fw", bus.fw, 2);
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.cfg_ready, 1);
    check("abort_fw", bus.fw, 2);
    check("abort_done", bus.done, 0);
    check("abort_strobe", bus.fw_strobe, 0);
    // abort with cfg_valid in idle rejects the config
    bus.cfg_start = 10'd600;
    bus.cfg_stop  = 10'd700;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    check("abort_rej_busy", bus.busy, 0);
    check("abort_rej_fw", bus.fw, 2);
    bus.cfg_valid = 1'b0;
    bus.abort = 1'b0;

    // Triangle with start == stop: holds forever, strobes only on load
    offer_cfg(10'd9, 10'd9, 10'd5, 16'd1, 1'b1);
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("tri_flat_fw%0d", i), bus.fw, 9);
      strobes += int'(bus.fw_strobe);
    end
    check("tri_flat_strobes", strobes, 1);
    check("tri_flat_busy", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("tri_flat_abort_busy", bus.busy, 0);

`ifdef FW_SWEEP_PAUSE_EN
    // Pause for 5 cycles during the first word: held 9 cycles
    pause_at  = 1;
    pause_len = 5;
    offer_cfg(10'd100, 10'd130, 10'd10, 16'd3, 1'b0);
    add_word(10'd100, 9); add_word(10'd110, 4); add_word(10'd120, 4);
    add_word(10'd130, 4); add_word(10'd130, 1);
    run_sweep("pause", 4, 1'b0);
    pause_at = -1;
`endif

    // Async reset mid-sweep
    offer_cfg(10'd100, 10'd130, 10'd10, 16'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("mid_fw", bus.fw, 110);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_fw", bus.fw, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_strobe", bus.fw_strobe, 0);
    check("mid_rst_ready", bus.cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_ready", bus.cfg_ready, 1);
    check("mid_post_fw", bus.fw, 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
